vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_ctrl.sv | 101 ++++++++++
 tb/tb_vga_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_ctrl
//  Purpose  : VGA raster timing generator. Free-running horizontal/vertical
//             pixel counters with combinational active-low sync decodes and a
//             visible-area flag. Timing is fully parameterised; defaults give
//             640x480 @ 60 Hz (800 x 525 total).
//  Options  : VGA_CTRL_PIXDIV_EN - when defined, an internal divide-by-4
//             produces the pixel tick (one pixel every 4 clk). When undefined,
//             every clk is a pixel and no divider exists.
//  Ports    : clk    - system clock, all state changes on rising edge
//             reset  - synchronous, active-high; returns raster to (0,0)
//             hsync  - horizontal sync, active-low
//             vsync  - vertical sync, active-low
//             valid  - current pixel lies in the visible area
//             h_cnt  - current pixel column, 0 .. H_TOTAL-1
//             v_cnt  - current line, 0 .. V_TOTAL-1
//  Revision : 1.0 - initial release
// ============================================================================
module vga_ctrl #(
   parameter int H_DISP = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_DISP = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       valid,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt
);

   localparam int         C_H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int         C_V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] C_H_LAST   = 10'(C_H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST   = 10'(C_V_TOTAL - 1);
   localparam logic [9:0] C_H_VIS    = 10'(H_DISP);
   localparam logic [9:0] C_V_VIS    = 10'(V_DISP);
   localparam logic [9:0] C_HS_START = 10'(H_DISP + H_FP);
   localparam logic [9:0] C_HS_END   = 10'(H_DISP + H_FP + H_SYNC);
   localparam logic [9:0] C_VS_START = 10'(V_DISP + V_FP);
   localparam logic [9:0] C_VS_END   = 10'(V_DISP + V_FP + V_SYNC);

   logic       w_pix_tick;
   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;

`ifdef VGA_CTRL_PIXDIV_EN
   // Divide-by-4: the tick fires on the last phase so each counter value is
   // held for exactly four clocks, starting from a fresh phase after reset.
   logic [1:0] r_pix_div;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pix_div <= 2'd0;
      end else begin
         r_pix_div <= r_pix_div + 2'd1;
      end
   end

   assign w_pix_tick = (r_pix_div == 2'd3);
`else
   assign w_pix_tick = 1'b1;
`endif

   // Reset is checked first so it overrides a coincident pixel tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= 10'd0;
      end else if (w_pix_tick) begin
         if (r_h_cnt == C_H_LAST) begin
            r_h_cnt <= 10'd0;
            if (r_v_cnt == C_V_LAST) begin
               r_v_cnt <= 10'd0;
            end else begin
               r_v_cnt <= r_v_cnt + 10'd1;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end
   end

   assign h_cnt = r_h_cnt;
   assign v_cnt = r_v_cnt;

   // Pure decodes of the counters: no extra pipeline stage, so sync and
   // valid line up with the counter values they describe.
   assign hsync = ~((r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END));
   assign vsync = ~((r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END));
   assign valid = (r_h_cnt < C_H_VIS) && (r_v_cnt < C_V_VIS);

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_ctrl
//  Purpose  : Self-checking bench for vga_ctrl. Two instances run side by
//             side from one clock/reset: one with default 640x480 timing and
//             one with a tiny raster so whole frames fit in a short run.
//             Expected outputs come from a raster-position model: the number
//             of clocks since reset is turned into a pixel index, then into
//             (column, line) by division, and sync/valid follow from ranges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_ctrl;

`ifdef VGA_CTRL_PIXDIV_EN
   localparam int CPP = 4;
`else
   localparam int CPP = 1;
`endif

   // Small raster: 32 x 19 total, 20 x 12 visible.
   localparam int S_HD = 20, S_HF = 3, S_HS = 5, S_HB = 4;
   localparam int S_VD = 12, S_VF = 2, S_VS = 2, S_VB = 3;
   localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

   logic clk;
   logic reset;

   logic       d_hsync, d_vsync, d_valid;
   logic [9:0] d_h, d_v;
   logic       s_hsync, s_vsync, s_valid;
   logic [9:0] s_h, s_v;

   logic [22:0] obs_d, obs_s, exp_d, exp_s;
   assign obs_d = {d_hsync, d_vsync, d_valid, d_h, d_v};
   assign obs_s = {s_hsync, s_vsync, s_valid, s_h, s_v};

   int n;          // clocks since the last reset edge
   int vectors;
   int miscompares;

   vga_ctrl dut_dflt (
      .clk   (clk),
      .reset (reset),
      .hsync (d_hsync),
      .vsync (d_vsync),
      .valid (d_valid),
      .h_cnt (d_h),
      .v_cnt (d_v)
   );

   vga_ctrl #(
      .H_DISP (S_HD), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_DISP (S_VD), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
   ) dut_small (
      .clk   (clk),
      .reset (reset),
      .hsync (s_hsync),
      .vsync (s_vsync),
      .valid (s_valid),
      .h_cnt (s_h),
      .v_cnt (s_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raster position after 'cnt' clocks out of reset.
   function automatic logic [22:0] ref_out(int cnt, int hd, int hf, int hs, int hb,
                                           int vd, int vf, int vs, int vb);
      int ht, vt, pos, h, v;
      logic hs_n, vs_n, vis;
      ht   = hd + hf + hs + hb;
      vt   = vd + vf + vs + vb;
      pos  = (cnt / CPP) % (ht * vt);
      h    = pos % ht;
      v    = pos / ht;
      hs_n = (h >= hd + hf && h < hd + hf + hs) ? 1'b0 : 1'b1;
      vs_n = (v >= vd + vf && v < vd + vf + vs) ? 1'b0 : 1'b1;
      vis  = (h < hd && v < vd) ? 1'b1 : 1'b0;
      return {hs_n, vs_n, vis, 10'(h), 10'(v)};
   endfunction

   function automatic logic [22:0] ref_dflt(int cnt);
      return ref_out(cnt, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction

   function automatic logic [22:0] ref_small(int cnt);
      return ref_out(cnt, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
   endfunction

   // Advance one clock; inputs change 1 time unit after the edge and
   // outputs are sampled there, well away from the next rising edge.
   task automatic step();
      @(posedge clk);
      if (reset) n = 0;
      else       n = n + 1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (obs_d !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin
            miscompares++;
            $display("FAIL reset_dflt cycle %0d: got %h want %h", i, obs_d, {3'b111, 20'd0});
         end
         vectors++;
         if (obs_s !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin
            miscompares++;
            $display("FAIL reset_small cycle %0d: got %h want %h", i, obs_s, {3'b111, 20'd0});
         end
      end
      reset = 1'b0;
   endtask

   // Two full default lines: every cycle against the model, plus hsync width
   // and visible width counted over the first line.
   task automatic test_line();
      int hs_low, vis_cnt;
      hs_low  = 0;
      vis_cnt = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 2 * 800 * CPP; i++) begin
         exp_d = ref_dflt(n);
         exp_s = ref_small(n);
         vectors++;
         if (obs_d !== exp_d) begin
            miscompares++;
            $display("FAIL line_dflt n=%0d: got %h want %h", n, obs_d, exp_d);
         end
         vectors++;
         if (obs_s !== exp_s) begin
            miscompares++;
            $display("FAIL line_small n=%0d: got %h want %h", n, obs_s, exp_s);
         end
         if (i < 800 * CPP && !d_hsync) hs_low++;
         if (i < 800 * CPP && d_valid)  vis_cnt++;
         step();
      end
      vectors++;
      if (hs_low !== 96 * CPP) begin
         miscompares++;
         $display("FAIL hsync_width: got %0d clk want %0d", hs_low, 96 * CPP);
      end
      vectors++;
      if (vis_cnt !== 640 * CPP) begin
         miscompares++;
         $display("FAIL line_visible: got %0d clk want %0d", vis_cnt, 640 * CPP);
      end
      vectors++;
      if ({d_h, d_v} !== {10'd0, 10'd2}) begin
         miscompares++;
         $display("FAIL line_wrap: got h=%0d v=%0d want h=0 v=2", d_h, d_v);
      end
   endtask

   // Full frames of the small raster: vsync width, visible pixel count and
   // the return to (0,0) after exactly one frame period.
   task automatic test_frame();
      int vs_low, vis_cnt;
      vs_low  = 0;
      vis_cnt = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < S_HT * S_VT * CPP; i++) begin
         exp_s = ref_small(n);
         vectors++;
         if (obs_s !== exp_s) begin
            miscompares++;
            $display("FAIL frame_small n=%0d: got %h want %h", n, obs_s, exp_s);
         end
         if (!s_vsync) vs_low++;
         if (s_valid)  vis_cnt++;
         step();
      end
      vectors++;
      if (vs_low !== S_VS * S_HT * CPP) begin
         miscompares++;
         $display("FAIL vsync_width: got %0d clk want %0d", vs_low, S_VS * S_HT * CPP);
      end
      vectors++;
      if (vis_cnt !== S_HD * S_VD * CPP) begin
         miscompares++;
         $display("FAIL frame_visible: got %0d clk want %0d", vis_cnt, S_HD * S_VD * CPP);
      end
      vectors++;
      if ({s_h, s_v} !== 20'd0) begin
         miscompares++;
         $display("FAIL frame_wrap: got h=%0d v=%0d want h=0 v=0", s_h, s_v);
      end
   endtask

   // Reset landing inside both sync pulses must restart cleanly at (0,0).
   task automatic test_reset_midframe();
      reset = 1'b1;
      step();
      reset = 1'b0;
      // small raster: column 25 (inside hsync) on line 15 (last vsync line)
      while (n < (15 * S_HT + 25) * CPP) step();
      vectors++;
      if ({s_hsync, s_vsync, s_h, s_v} !== {1'b0, 1'b0, 10'd25, 10'd15}) begin
         miscompares++;
         $display("FAIL midframe_pre: got hs=%b vs=%b h=%0d v=%0d want 0 0 25 15",
                  s_hsync, s_vsync, s_h, s_v);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      vectors++;
      if (obs_s !== {3'b111, 20'd0}) begin
         miscompares++;
         $display("FAIL midframe_small: got %h want %h", obs_s, {3'b111, 20'd0});
      end
      // default raster: column 700 (inside hsync) on line 1
      while (n < (800 + 700) * CPP) step();
      vectors++;
      if ({d_hsync, d_h, d_v} !== {1'b0, 10'd700, 10'd1}) begin
         miscompares++;
         $display("FAIL midline_pre: got hs=%b h=%0d v=%0d want 0 700 1", d_hsync, d_h, d_v);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      vectors++;
      if (obs_d !== {3'b111, 20'd0}) begin
         miscompares++;
         $display("FAIL midline_dflt: got %h want %h", obs_d, {3'b111, 20'd0});
      end
   endtask

   // Random run lengths interleaved with random short reset pulses.
   task automatic test_random();
      int len, rlen;
      for (int it = 0; it < 30; it++) begin
         len = int'($urandom_range(1, 2000));
         for (int i = 0; i < len; i++) begin
            step();
            exp_d = ref_dflt(n);
            exp_s = ref_small(n);
            vectors++;
            if (obs_d !== exp_d) begin
               miscompares++;
               $display("FAIL rand_dflt it=%0d n=%0d: got %h want %h", it, n, obs_d, exp_d);
            end
            vectors++;
            if (obs_s !== exp_s) begin
               miscompares++;
               $display("FAIL rand_small it=%0d n=%0d: got %h want %h", it, n, obs_s, exp_s);
            end
         end
         if ($urandom_range(0, 2) == 0) begin
            rlen  = int'($urandom_range(1, 3));
            reset = 1'b1;
            for (int r = 0; r < rlen; r++) step();
            reset = 1'b0;
            vectors++;
            if ({obs_d, obs_s} !== {3'b111, 20'd0, 3'b111, 20'd0}) begin
               miscompares++;
               $display("FAIL rand_reset it=%0d: got %h / %h want all-zero counters",
                        it, obs_d, obs_s);
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      n           = 0;
      reset       = 1'b1;
      test_reset();
      test_line();
      test_frame();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
